// File: rtl/controlador_busca.sv
// Instruction-fetch sequencer: owns the PC, steps/redirects it, stalls on pausa, halts out of range.
// Optional retired-instruction counter enabled by defining CONTADOR_INSTR_EN.
module controlador_busca #(
  parameter logic [31:0] PC_INICIAL = 32'd0,
  parameter int          TAM_MEM    = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inicia,
  input  logic        pausa,
  input  logic        desvio,
  input  logic [15:0] imediato,
  output logic [31:0] endereco,
  output logic [31:0] pc_mais4,
  output logic        valido,
  output logic        fim,
  output logic [1:0]  estado,
  output logic [31:0] contador_instr
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    ESPERA = 2'd2,
    PARADO = 2'd3
  } estado_t;

  localparam logic [31:0] LIMITE = 32'(4 * TAM_MEM);

  // Next sequential PC; a taken branch adds the word offset, sign-extended and scaled to bytes.
  function automatic logic [31:0] calc_prox(input logic [31:0] pc,
                                            input logic        tomado,
                                            input logic [15:0] imed);
    logic signed [31:0] desloc;
    desloc = {{14{imed[15]}}, imed, 2'b00};
    return pc + 32'd4 + (tomado ? unsigned'(desloc) : 32'd0);
  endfunction

  // Unsigned compare also catches targets that wrapped below zero.
  function automatic logic fora_faixa(input logic [31:0] pc);
    return pc >= LIMITE;
  endfunction

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] prox;

  assign prox = calc_prox(pc_q, desvio, imediato);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      pc_q     <= PC_INICIAL;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    case (estado_q)
      OCIOSO: begin
        if (inicia) estado_d = BUSCA;
      end
      BUSCA: begin
        // A stall drops any branch request; the requester presents it again afterwards.
        if (pausa) begin
          estado_d = ESPERA;
        end else if (fora_faixa(prox)) begin
          estado_d = PARADO;
        end else begin
          pc_d = prox;
        end
      end
      ESPERA: begin
        if (!pausa) estado_d = BUSCA;
      end
      PARADO: begin
        if (inicia) begin
          pc_d     = PC_INICIAL;
          estado_d = BUSCA;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign endereco = pc_q;
  assign pc_mais4 = pc_q + 32'd4;
  assign valido   = (estado_q == BUSCA);
  assign fim      = (estado_q == PARADO);
  assign estado   = estado_q;

`ifdef CONTADOR_INSTR_EN
  logic        conta;
  logic [31:0] contador_q;

  // The halting cycle still retires the instruction at the last legal PC.
  assign conta = (estado_q == BUSCA) && !pausa;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador_q <= 32'd0;
    end else if (conta) begin
      contador_q <= contador_q + 32'd1;
    end
  end

  assign contador_instr = contador_q;
`else
  assign contador_instr = 32'd0;
`endif

endmodule

// File: tb/tb_controlador_busca.sv
// Self-checking bench for controlador_busca: directed table, corner sequences and random run
// against a behavioural model of the fetch sequencer.
module tb_controlador_busca;

  localparam logic [31:0] PC0 = 32'd0;
  localparam int          TAM = 32;

  logic        clock;
  logic        reset_n;
  logic        inicia;
  logic        pausa;
  logic        desvio;
  logic [15:0] imediato;
  logic [31:0] endereco;
  logic [31:0] pc_mais4;
  logic        valido;
  logic        fim;
  logic [1:0]  estado;
  logic [31:0] contador_instr;

  controlador_busca #(.PC_INICIAL(PC0), .TAM_MEM(TAM)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .inicia         (inicia),
    .pausa          (pausa),
    .desvio         (desvio),
    .imediato       (imediato),
    .endereco       (endereco),
    .pc_mais4       (pc_mais4),
    .valido         (valido),
    .fim            (fim),
    .estado         (estado),
    .contador_instr (contador_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: what the sequencer is doing, the PC, and instructions retired.
  typedef enum {M_IDLE, M_RUN, M_WAIT, M_HALT} modo_t;
  modo_t       m_modo;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_estado();
    case (m_modo)
      M_IDLE:  return 2'd0;
      M_RUN:   return 2'd1;
      M_WAIT:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef CONTADOR_INSTR_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic model_reset();
    m_modo = M_IDLE;
    m_pc   = PC0;
    m_cnt  = 32'd0;
  endtask

  task automatic model_step(input bit ini, input bit pau, input bit des, input logic [15:0] imm);
    longint alvo;
    case (m_modo)
      M_IDLE: if (ini) m_modo = M_RUN;
      M_RUN: begin
        if (pau) begin
          m_modo = M_WAIT;
        end else begin
          m_cnt = m_cnt + 1;
          alvo = longint'(m_pc) + 4 + (des ? longint'($signed(imm)) * 4 : 0);
          alvo = alvo & 64'h0000_0000_FFFF_FFFF;
          if (alvo >= 4 * TAM) m_modo = M_HALT;
          else m_pc = alvo[31:0];
        end
      end
      M_WAIT: if (!pau) m_modo = M_RUN;
      M_HALT: if (ini) begin
        m_pc   = PC0;
        m_modo = M_RUN;
      end
      default: m_modo = M_IDLE;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, " endereco"}, endereco, m_pc);
    chk({tag, " pc_mais4"}, pc_mais4, m_pc + 32'd4);
    chk({tag, " valido"}, {31'd0, valido}, {31'd0, m_modo == M_RUN});
    chk({tag, " fim"}, {31'd0, fim}, {31'd0, m_modo == M_HALT});
    chk({tag, " estado"}, {30'd0, estado}, {30'd0, exp_estado()});
    chk({tag, " contador"}, contador_instr, exp_cnt(m_cnt));
  endtask

  task automatic cyc(input string tag, input bit ini, input bit pau, input bit des,
                     input logic [15:0] imm);
    inicia   = ini;
    pausa    = pau;
    desvio   = des;
    imediato = imm;
    model_step(ini, pau, des, imm);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    inicia   = 1'b0;
    pausa    = 1'b0;
    desvio   = 1'b0;
    imediato = 16'h0;
    reset_n  = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_all("reset");
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          ini;
    bit          pau;
    bit          des;
    logic [15:0] imm;
    logic [31:0] e_end;
    bit          e_val;
    bit          e_fim;
    logic [1:0]  e_est;
  } vetor_t;

  vetor_t tab[14];

  initial begin
    // Expected outputs after the edge on which each row's inputs were applied.
    tab[0]  = '{1, 0, 0, 16'h0000, 32'd0,  1, 0, 2'd1};
    tab[1]  = '{0, 0, 0, 16'h0000, 32'd4,  1, 0, 2'd1};
    tab[2]  = '{0, 0, 0, 16'h0000, 32'd8,  1, 0, 2'd1};
    tab[3]  = '{0, 1, 1, 16'h0005, 32'd8,  0, 0, 2'd2};
    tab[4]  = '{0, 1, 1, 16'h0005, 32'd8,  0, 0, 2'd2};
    tab[5]  = '{0, 0, 0, 16'h0000, 32'd8,  1, 0, 2'd1};
    tab[6]  = '{0, 0, 0, 16'h0000, 32'd12, 1, 0, 2'd1};
    tab[7]  = '{1, 0, 0, 16'h0000, 32'd16, 1, 0, 2'd1};
    tab[8]  = '{0, 0, 1, 16'h000D, 32'd72, 1, 0, 2'd1};
    tab[9]  = '{0, 0, 1, 16'h0001, 32'd80, 1, 0, 2'd1};
    tab[10] = '{0, 0, 1, 16'hFFF0, 32'd20, 1, 0, 2'd1};
    tab[11] = '{1, 1, 0, 16'h0000, 32'd20, 0, 0, 2'd2};
    tab[12] = '{1, 0, 0, 16'h0000, 32'd20, 1, 0, 2'd1};
    tab[13] = '{0, 0, 0, 16'h0000, 32'd24, 1, 0, 2'd1};

    reset_n = 1'b0;
    #3;
    chk("async reset estado", {30'd0, estado}, 32'd0);
    chk("async reset endereco", endereco, PC0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      cyc($sformatf("tab%0d", i), tab[i].ini, tab[i].pau, tab[i].des, tab[i].imm);
      chk($sformatf("tab%0d end", i), endereco, tab[i].e_end);
      chk($sformatf("tab%0d val", i), {31'd0, valido}, {31'd0, tab[i].e_val});
      chk($sformatf("tab%0d fim", i), {31'd0, fim}, {31'd0, tab[i].e_fim});
      chk($sformatf("tab%0d est", i), {30'd0, estado}, {30'd0, tab[i].e_est});
    end

    // Run off the end of memory, then restart.
    do_reset();
    cyc("halt start", 1, 0, 0, 16'h0);
    for (int i = 0; i < 31; i++) cyc("halt run", 0, 0, 0, 16'h0);
    chk("last legal pc", endereco, 32'd124);
    cyc("halt edge", 0, 0, 0, 16'h0);
    chk("halt endereco", endereco, 32'd124);
    chk("halt fim", {31'd0, fim}, 32'd1);
    chk("halt valido", {31'd0, valido}, 32'd0);
    chk("halt estado", {30'd0, estado}, 32'd3);
`ifdef CONTADOR_INSTR_EN
    chk("halt contador", contador_instr, 32'd32);
`else
    chk("halt contador", contador_instr, 32'd0);
`endif
    cyc("halt hold", 0, 1, 1, 16'h0003);
    chk("halt hold end", endereco, 32'd124);
    cyc("restart", 1, 0, 0, 16'h0);
    chk("restart end", endereco, 32'd0);
    chk("restart valido", {31'd0, valido}, 32'd1);

    // Backward branch from 0 wraps past zero and must halt at PC 0.
    cyc("wrap", 0, 0, 1, 16'hFFFE);
    chk("wrap end", endereco, 32'd0);
    chk("wrap fim", {31'd0, fim}, 32'd1);

    // Asynchronous reset between edges.
    cyc("arst restart", 1, 0, 0, 16'h0);
    for (int i = 0; i < 10; i++) cyc("arst run", 0, 0, 0, 16'h0);
    chk("arst pre end", endereco, 32'd40);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_all("arst idle");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit          ini, pau, des;
      logic [15:0] imm;
      ini = ($urandom_range(0, 7) == 0);
      pau = ($urandom_range(0, 3) == 0);
      des = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) imm = 16'($urandom_range(0, 24)) - 16'd8;
      else imm = 16'($urandom);
      cyc("rand", ini, pau, des, imm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
